sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Consumer/driver of the round-constant block_rom: accepts one 512-bit message block as 16 32-bit words and expands it into the 64-entry message schedule W[0..63].
- Drives the ROM address so each output beat carries W[t] together with K[t] fetched from the 1-cycle-latency ROM.
- Feeds the downstream compression round datapath over a valid/ready stream.

Parameters:
- ROUNDS, 64, schedule length and ROM depth; rom_addr width is $clog2(ROUNDS). Only 64 is supported.
- K_INIT, "../mems/round_constants.memh", passed through by the integrator to the paired block_rom. Unused inside this block.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts a word this cycle.
- in_word  input  32  message word, big-endian order, W[0] first.
- rom_addr  output  6  address to block_rom (registered inside the ROM; data returns next cycle).
- rom_data  input  32  K value from block_rom.
- out_valid  output  1  out_w/out_k/out_t valid.
- out_ready  input  1  downstream accepts the beat.
- out_w  output  32  W[t].
- out_k  output  32  K[t] (= rom_data).
- out_t  output  6  round index t.
- out_last  output  1  high with t == 63.

Behaviour:
- Storage: 16-word window win[0..15]; out_w = win[0].
- States: LOAD (reset state), RUN.
- Reset (rst_n low, async):
  - State LOAD; load_cnt = 0; t = 0; win cleared to 0.
  - out_valid = 0; in_ready = 0 while rst_n is low.
- LOAD:
  - in_ready = 1; out_valid = 0; rom_addr = 0.
  - On in_valid & in_ready: shift window (win[i] <= win[i+1], win[15] <= in_word); load_cnt++.
  - On the 16th accepted word (load_cnt == 15): go to RUN, t = 0. win[0] then holds W[0].
  - in_ready drops the cycle after the 16th accept.
  - Gaps in in_valid are allowed.
- K alignment:
  - rom_addr is held at 0 throughout LOAD, which lasts at least 16 cycles.
  - On entry to RUN, rom_data already holds K[0]; no prefetch state is needed.
- RUN:
  - out_valid = 1; in_ready = 0; out_t = t; out_k = rom_data; out_last = (t == 63).
  - rom_addr = fire ? t+1 : t, where fire = out_valid & out_ready. This is the only combinational path from out_ready to an output; it is intentional.
  - Stall (out_ready = 0): all outputs hold stable; rom_addr = t, so the ROM re-reads K[t].
  - On fire: t++. Shift the window with win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], addition mod 2^32.
    - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
    - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Values computed for t >= 48 are never emitted; this is harmless.
  - On fire with t == 63: go to LOAD, load_cnt = 0, t = 0. rom_addr = 0 that cycle (wrap; t+1 is not used).
  - out_valid deasserts the next cycle and in_ready asserts the next cycle.
- Throughput: one beat per cycle under continuous out_ready. A block takes at least 16 cycles to load plus 64 cycles to emit; there is no overlap of LOAD and RUN.
- No simultaneous in/out handshakes are possible (the states are exclusive).
- Reset mid-operation: the partial block is discarded. out_valid drops immediately (async) and the block returns to LOAD with load_cnt = 0.
- in_word/in_valid are ignored outside LOAD. out_ready is ignored outside RUN.

Test Plan:
- "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), out_ready = 1 -> expected beats:
  - t0: w = 0x61626380, k = 0x428a2f98.
  - t15: w = 0x00000018.
  - t16: w = 0x61626380.
  - t17: w = 0x000f0000.
  - t63: k = 0xc67178f2 with out_last = 1.
  - Exactly 64 beats, then in_ready = 1.
- Random out_ready backpressure on the "abc" block -> beat sequence identical to the no-stall run. Outputs stay stable across every stall cycle, and out_k matches K[t] on every beat.
- in_valid with gaps (one word every 3 cycles) -> out_valid rises exactly one cycle after the 16th accept. W[0..15] are output in order.
- Two back-to-back blocks -> the second block's t0 carries k = 0x428a2f98 (rom_addr wrapped to 0) and the correct W. No beat is lost or duplicated.
- rst_n pulsed low at t = 30 -> out_valid = 0 immediately. After release the block is in LOAD with in_ready = 1, and a fresh "abc" load reproduces scenario 1.
- in_valid asserted during RUN, and out_ready toggled during LOAD -> no state change, no words consumed, no beats emitted.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule expander paired with the round-constant ROM
//
// Accepts one 512-bit block as 16 big-endian 32-bit words, then streams
// W[0..63] together with K[0..63] read from a 1-cycle-latency block_rom.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   in_word is valid
//   in_ready   block accepts a word this cycle (LOAD only)
//   in_word    message word, W[0] first
//   rom_addr   address to block_rom (data returns next cycle)
//   rom_data   K value from block_rom
//   out_valid  out_w/out_k/out_t valid (RUN only)
//   out_ready  downstream accepts the beat
//   out_w      W[t]
//   out_k      K[t]
//   out_t      round index t
//   out_last   high with t == ROUNDS-1
module sha256_msg_schedule #(
  parameter int    ROUNDS = 64,
  parameter string K_INIT = "../mems/round_constants.memh"
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_word,
  output logic [$clog2(ROUNDS)-1:0] rom_addr,
  input  logic [31:0]               rom_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_w,
  output logic [31:0]               out_k,
  output logic [$clog2(ROUNDS)-1:0] out_t,
  output logic                      out_last
);

  localparam int AW = $clog2(ROUNDS);
  localparam logic [AW-1:0] T_LAST = AW'(ROUNDS - 1);

  // Only the standard 64-round schedule exists; K_INIT belongs to the ROM.
  if (ROUNDS != 64 || K_INIT == "") begin : g_bad_cfg
    $error("sha256_msg_schedule: unsupported configuration");
  end

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t        state;
  logic [3:0]    load_cnt;
  logic [AW-1:0] t;
  logic [31:0]   win [16];

  logic          fire;
  logic [31:0]   next_w;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win[k] holds W[t+k], so this is W[t+16].
  assign next_w = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // in_ready is gated by rst_n so it is low for the whole reset pulse.
  assign in_ready  = rst_n && (state == LOAD);
  assign out_valid = (state == RUN);
  assign fire      = out_valid && out_ready;

  assign out_w    = win[0];
  assign out_k    = rom_data;
  assign out_t    = t;
  assign out_last = (state == RUN) && (t == T_LAST);

  // The ROM registers its address, so fetching K[t+1] on a fire lines it up
  // with the next beat. LOAD holds address 0 for >= 16 cycles, so K[0] is
  // already waiting on entry to RUN. This is the one out_ready->output path.
  always_comb begin
    rom_addr = '0;
    if (state == RUN) begin
      if (!fire) begin
        rom_addr = t;
      end else if (t != T_LAST) begin
        rom_addr = t + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      t        <= '0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < 15; i++) begin
              win[i] <= win[i+1];
            end
            win[15]  <= in_word;
            load_cnt <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state <= RUN;
              t     <= '0;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            for (int i = 0; i < 15; i++) begin
              win[i] <= win[i+1];
            end
            // Words produced for t >= 48 are never emitted; harmless.
            win[15] <= next_w;
            if (t == T_LAST) begin
              state    <= LOAD;
              load_cnt <= '0;
              t        <= '0;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - scoreboard bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [31:0] out_k;
  logic [5:0]  out_t;
  logic        out_last;

  sha256_msg_schedule #(
    .ROUNDS(64),
    .K_INIT("../mems/round_constants.memh")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_w    (out_w),
    .out_k    (out_k),
    .out_t    (out_t),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] k_tab [64];
  initial begin
    k_tab = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
  end

  // block_rom stand-in: registered read, one cycle of latency.
  always @(posedge clk) rom_data <= k_tab[rom_addr];

  typedef struct {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  t;
    logic        last;
  } beat_t;

  beat_t       sb [$];
  beat_t       exp_b;
  beat_t       hold;
  logic        stalled;
  int          beats;
  int          checks;
  int          failures;
  int          rdy_mode;
  logic [31:0] got_w [64];
  logic [31:0] got_k [64];
  logic        got_last [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule computed straight from the FIPS 180-4 recurrence.
  task automatic push_expected(input logic [31:0] blk [16]);
    logic [31:0] w [64];
    beat_t b;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[i];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10))
                + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                + w[i-16];
      b.w    = w[i];
      b.k    = k_tab[i];
      b.t    = 6'(i);
      b.last = (i == 63);
      sb.push_back(b);
    end
  endtask

  // Output monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      if (stalled) begin
        check("stall_w", out_w, hold.w);
        check("stall_k", out_k, hold.k);
        check("stall_t", 32'(out_t), 32'(hold.t));
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(out_t), 32'hffff_ffff);
        end else begin
          exp_b = sb.pop_front();
          check("beat_w", out_w, exp_b.w);
          check("beat_k", out_k, exp_b.k);
          check("beat_t", 32'(out_t), 32'(exp_b.t));
          check("beat_last", 32'(out_last), 32'(exp_b.last));
        end
        got_w[out_t]    = out_w;
        got_k[out_t]    = out_k;
        got_last[out_t] = out_last;
        beats++;
        stalled = 1'b0;
      end else begin
        hold.w  = out_w;
        hold.k  = out_k;
        hold.t  = out_t;
        stalled = 1'b1;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // out_ready driver; random mode also toggles it during LOAD.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic load_block(input logic [31:0] blk [16], input int gap);
    logic acc;
    int   n;
    push_expected(blk);
    for (int i = 0; i < 16; i++) begin
      in_word  = blk[i];
      in_valid = 1'b1;
      n = 0;
      do begin
        if (i == 15) check("valid_before_16th", 32'(out_valid), 32'd0);
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 1000);
      if (!acc) check("accept_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
      if (i == 15) check("valid_after_16th", 32'(out_valid), 32'd1);
      if (i < 15) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat_wait", 32'(beats), 32'(target));
  endtask

  task automatic finish_block();
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] abc [16];
  logic [31:0] rb1 [16];
  logic [31:0] rb2 [16];

  task automatic check_abc_constants();
    check("abc_w0", got_w[0], 32'h61626380);
    check("abc_k0", got_k[0], 32'h428a2f98);
    check("abc_w15", got_w[15], 32'h00000018);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000f0000);
    check("abc_k63", got_k[63], 32'hc67178f2);
    check("abc_last63", 32'(got_last[63]), 32'd1);
    check("abc_last62", 32'(got_last[62]), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    beats    = 0;
    rdy_mode = 0;
    stalled  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    for (int i = 0; i < 16; i++) begin
      abc[i] = '0;
      rb1[i] = $urandom;
      rb2[i] = $urandom;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // "abc" block, no backpressure
    beats = 0;
    load_block(abc, 0);
    wait_beats(64);
    @(posedge clk);
    #1;
    finish_block();
    check_abc_constants();

    // "abc" block under random backpressure (also toggles out_ready in LOAD)
    rdy_mode = 1;
    beats = 0;
    load_block(abc, 0);
    wait_beats(64);
    @(posedge clk);
    #1;
    finish_block();
    check_abc_constants();

    // one word every 3 cycles
    rdy_mode = 0;
    beats = 0;
    load_block(rb1, 2);
    wait_beats(64);
    @(posedge clk);
    #1;
    finish_block();

    // back-to-back blocks; in_valid held during RUN of the first
    beats = 0;
    load_block(rb1, 0);
    in_valid = 1'b1;
    in_word  = 32'hdeadbeef;
    repeat (10) begin
      check("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    load_block(rb2, 0);
    check("b2b_sb_depth", 32'(sb.size()), 32'd64);
    wait_beats(128);
    @(posedge clk);
    #1;
    check("b2b_k0", got_k[0], 32'h428a2f98);
    check("b2b_w0", got_w[0], rb2[0]);
    finish_block();

    // reset at t = 30
    beats = 0;
    load_block(abc, 0);
    wait_beats(30);
    check("pre_rst_t", 32'(out_t), 32'd30);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    beats = 0;
    load_block(abc, 0);
    wait_beats(64);
    @(posedge clk);
    #1;
    finish_block();
    check_abc_constants();

    repeat (5) @(posedge clk);
    #1;
    check("final_beats", 32'(beats), 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
